// File: rtl/hud_pkg.sv
// Shared types and constants for the HUD score/time BCD converter.
// Latency and backpressure: none here, declarations only.
package hud_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } hud_state_e;

  // Digit code the character renderer draws as an empty cell.
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  localparam int DEF_SCORE_W   = 8;
  localparam int DEF_TIME_W    = 12;
  localparam int DEF_SCORE_DIG = 3;
  localparam int DEF_TIME_DIG  = 4;

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift {bcd, bin} left by one.
// Purely combinational, zero latency, no flow control.
module bcd_dd_step #(
  parameter int DIG   = 3,
  parameter int BIN_W = 12
) (
  input  logic [4*DIG-1:0] bcd_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [4*DIG-1:0] bcd_o,
  output logic [BIN_W-1:0] bin_o
);

  logic [4*DIG-2:0] adj;
  logic [3:0]       top_n;

  always_comb begin
    adj   = '0;
    top_n = bcd_i[4*DIG-1 -: 4];
    for (int i = 0; i < DIG - 1; i++) begin
      adj[4*i +: 4] = (bcd_i[4*i +: 4] >= 4'd5) ? bcd_i[4*i +: 4] + 4'd3 : bcd_i[4*i +: 4];
    end
    // Top nibble's bit 3 is shifted out; digit coverage keeps it zero, so only 3 bits are kept.
    adj[4*DIG-2 -: 3] = top_n[2:0] + ((top_n >= 4'd5) ? 3'd3 : 3'd0);
    bcd_o = {adj, bin_i[BIN_W-1]};
    bin_o = {bin_i[BIN_W-2:0], 1'b0};
  end

endmodule

// File: rtl/hud_bcd_conv.sv
// Once per vsync rise, converts score and time to packed BCD, one bit per clock; result 14 clk after capture.
// Rises arriving while busy are dropped; HUD_BLANK_EN turns leading zero digits into blank cells.
module hud_bcd_conv
  import hud_pkg::*;
#(
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int TIME_W    = DEF_TIME_W,
  parameter int SCORE_DIG = DEF_SCORE_DIG,
  parameter int TIME_DIG  = DEF_TIME_DIG
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vs_in,
  input  logic [SCORE_W-1:0]     mole_score,
  input  logic [TIME_W-1:0]      left_time,
  output logic [4*SCORE_DIG-1:0] score_bcd,
  output logic [4*TIME_DIG-1:0]  time_bcd,
  output logic                   bcd_valid,
  output logic                   busy
);

  localparam int CNT_W = (TIME_W > 1) ? $clog2(TIME_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIME_W - 1);

  hud_state_e state_q, state_d;

  logic sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic vs_rise;

  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TIME_W-1:0]      s_bin_q, s_bin_d, s_bin_nx;
  logic [TIME_W-1:0]      t_bin_q, t_bin_d, t_bin_nx;
  logic [4*SCORE_DIG-1:0] s_acc_q, s_acc_d, s_acc_nx, s_fmt;
  logic [4*TIME_DIG-1:0]  t_acc_q, t_acc_d, t_acc_nx, t_fmt;

  logic                   upd_q, upd_d;
  logic                   bcd_valid_q, bcd_valid_d;
  logic [4*SCORE_DIG-1:0] score_bcd_q, score_bcd_d;
  logic [4*TIME_DIG-1:0]  time_bcd_q, time_bcd_d;

  assign vs_rise = sync2_q & ~hist_q;

  bcd_dd_step #(.DIG(SCORE_DIG), .BIN_W(TIME_W)) u_score_step (
    .bcd_i (s_acc_q),
    .bin_i (s_bin_q),
    .bcd_o (s_acc_nx),
    .bin_o (s_bin_nx)
  );

  bcd_dd_step #(.DIG(TIME_DIG), .BIN_W(TIME_W)) u_time_step (
    .bcd_i (t_acc_q),
    .bin_i (t_bin_q),
    .bcd_o (t_acc_nx),
    .bin_o (t_bin_nx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (vs_rise) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_cnt_q == LAST_CNT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin : datapath_comb
    sync1_d   = vs_in;
    sync2_d   = sync1_q;
    hist_d    = sync2_q;
    bit_cnt_d = bit_cnt_q;
    s_bin_d   = s_bin_q;
    t_bin_d   = t_bin_q;
    s_acc_d   = s_acc_q;
    t_acc_d   = t_acc_q;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise) begin
          s_bin_d   = TIME_W'(mole_score);
          t_bin_d   = left_time;
          s_acc_d   = '0;
          t_acc_d   = '0;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        s_bin_d   = s_bin_nx;
        t_bin_d   = t_bin_nx;
        s_acc_d   = s_acc_nx;
        t_acc_d   = t_acc_nx;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

`ifdef HUD_BLANK_EN
  logic s_lead, t_lead;
`endif

  always_comb begin : fmt_comb
    s_fmt = s_acc_q;
    t_fmt = t_acc_q;
`ifdef HUD_BLANK_EN
    s_lead = 1'b1;
    t_lead = 1'b1;
    for (int i = SCORE_DIG - 1; i > 0; i--) begin
      if (s_lead && s_fmt[4*i +: 4] == 4'd0) s_fmt[4*i +: 4] = BLANK_DIGIT;
      else                                   s_lead = 1'b0;
    end
    for (int i = TIME_DIG - 1; i > 0; i--) begin
      if (t_lead && t_fmt[4*i +: 4] == 4'd0) t_fmt[4*i +: 4] = BLANK_DIGIT;
      else                                   t_lead = 1'b0;
    end
`endif
  end

  // Accumulators stay put after DONE, so the output stage loads them one clock later.
  always_comb begin : output_comb
    busy        = (state_q != ST_IDLE);
    upd_d       = (state_q == ST_DONE);
    bcd_valid_d = upd_q;
    score_bcd_d = upd_q ? s_fmt : score_bcd_q;
    time_bcd_d  = upd_q ? t_fmt : time_bcd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= 1'b0;
      bit_cnt_q   <= '0;
      s_bin_q     <= '0;
      t_bin_q     <= '0;
      s_acc_q     <= '0;
      t_acc_q     <= '0;
      upd_q       <= 1'b0;
      bcd_valid_q <= 1'b0;
      score_bcd_q <= '0;
      time_bcd_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      bit_cnt_q   <= bit_cnt_d;
      s_bin_q     <= s_bin_d;
      t_bin_q     <= t_bin_d;
      s_acc_q     <= s_acc_d;
      t_acc_q     <= t_acc_d;
      upd_q       <= upd_d;
      bcd_valid_q <= bcd_valid_d;
      score_bcd_q <= score_bcd_d;
      time_bcd_q  <= time_bcd_d;
    end
  end

  assign score_bcd = score_bcd_q;
  assign time_bcd  = time_bcd_q;
  assign bcd_valid = bcd_valid_q;

endmodule
